// File: rtl/pipeline_mem_ext.sv
// pipeline_mem_ext: MEM stage with req/gnt/rvalid memory port, byte lanes, load extension, alignment and timeout checks.
module pipeline_mem_ext #(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [31:0]           rt_value,
  input  logic [31:0]           rd_value,
  input  logic [1:0]            mem_size,
  input  logic                  load_unsigned,
  input  logic                  memread_enable,
  input  logic                  memwrite_enable,
  input  logic                  alu_memop_disable,
  output logic [31:0]           out_value,
  output logic                  out_valid,
  output logic                  stall,
  output logic [2:0]            exception,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state;
  logic [7:0] cnt;
  logic [1:0] lane, size_q;
  logic uns_q, tmo_q;
  logic [31:0] data_q, wdata, ext;
  logic [3:0] be;
  logic [7:0] bsel;
  logic [15:0] hsel;
  logic op, aligned, accept, last, unused_bits;
  assign unused_bits = ^rd_value;
  assign op = in_valid & (memread_enable | memwrite_enable) & ~alu_memop_disable;
  assign aligned = mem_size == 2'b00 ? 1'b1 : mem_size == 2'b01 ? ~rd_value[0] : rd_value[1:0] == 2'b00;
  assign accept = state == IDLE & op & aligned;
  assign be = mem_size == 2'b00 ? 4'b0001 << rd_value[1:0] :
              mem_size == 2'b01 ? 4'b0011 << {rd_value[1], 1'b0} : 4'b1111;
  assign wdata = mem_size == 2'b00 ? {4{rt_value[7:0]}} : mem_size == 2'b01 ? {2{rt_value[15:0]}} : rt_value;
  assign bsel = mem_rdata[{lane, 3'b000} +: 8];
  assign hsel = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign ext = mem_we ? 32'd0 :
               size_q == 2'b00 ? {{24{~uns_q & bsel[7]}}, bsel} :
               size_q == 2'b01 ? {{16{~uns_q & hsel[15]}}, hsel} : mem_rdata;
  assign last = cnt == 8'(TIMEOUT - 1);
  assign stall = ~rst & (accept | state == REQ | state == WAIT);
  assign out_valid = state == RESP;
  assign out_value = out_valid ? data_q : 32'd0;
  // misalignment is reported combinationally; a timeout only surfaces in RESP
  assign exception = rst ? 3'd0 :
                     (state == IDLE & op & ~aligned) ? (memwrite_enable ? 3'd2 : 3'd1) :
                     (out_valid & tmo_q) ? 3'd3 : 3'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
      cnt <= '0;
      lane <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      tmo_q <= 1'b0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= REQ;
          mem_req <= 1'b1;
          mem_we <= memwrite_enable;
          mem_addr <= rd_value[ADDR_WIDTH-1:2];
          mem_wdata <= wdata;
          mem_be <= be;
          lane <= rd_value[1:0];
          size_q <= mem_size;
          uns_q <= load_unsigned;
          cnt <= '0;
          tmo_q <= 1'b0;
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          if (last) begin
            state <= RESP;
            mem_req <= 1'b0;
            tmo_q <= 1'b1;
            data_q <= '0;
          end else if (mem_gnt) begin
            state <= WAIT;
            mem_req <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (mem_rvalid) begin
            state <= RESP;
            data_q <= ext;
          end else if (last) begin
            state <= RESP;
            tmo_q <= 1'b1;
            data_q <= '0;
          end
        end
        RESP: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_mem_ext.sv
// tb_pipeline_mem_ext: randomized and directed checks of pipeline_mem_ext against a byte-lane arithmetic model.
module tb_pipeline_mem_ext;
  localparam int TIMEOUT = 15;
  logic clk = 0, rst = 1, in_valid = 0, load_unsigned = 0, memread_enable = 0, memwrite_enable = 0;
  logic alu_memop_disable = 0, mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] rt_value = 0, rd_value = 0, mem_rdata = 0;
  logic [1:0] mem_size = 0;
  logic [31:0] out_value, mem_wdata;
  logic out_valid, stall, mem_req, mem_we;
  logic [2:0] exception;
  logic [13:0] mem_addr;
  logic [3:0] mem_be;
  int checks = 0, failures = 0;
  int o_lat, o_stall;
  logic o_valid, o_seen, o_unstable, o_req_resp, o_we;
  logic [31:0] o_val, o_wdata;
  logic [2:0] o_exc;
  logic [13:0] o_addr;
  logic [3:0] o_be;

  pipeline_mem_ext #(.ADDR_WIDTH(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .rt_value(rt_value), .rd_value(rd_value),
    .mem_size(mem_size), .load_unsigned(load_unsigned), .memread_enable(memread_enable),
    .memwrite_enable(memwrite_enable), .alu_memop_disable(alu_memop_disable),
    .out_value(out_value), .out_valid(out_valid), .stall(stall), .exception(exception),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr, input logic [1:0] sz, input logic uns);
    longint v, span;
    if (nbytes(sz) == 4) return rdata;
    span = longint'(1) << (8 * nbytes(sz));
    v = (longint'(rdata) >> (8 * (addr % 4))) % span;
    if (!uns && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] sz);
    int m;
    m = ((1 << nbytes(sz)) - 1) << (addr % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] rt, input logic [1:0] sz);
    if (sz == 2'd0) return (rt % 256) * 32'h01010101;
    if (sz == 2'd1) return (rt % 65536) * 32'h00010001;
    return rt;
  endfunction

  task automatic drive(input logic [31:0] addr, input logic [31:0] rt, input logic [1:0] sz, input logic uns, input logic we);
    in_valid = 1; rd_value = addr; rt_value = rt; mem_size = sz; load_unsigned = uns;
    memwrite_enable = we; memread_enable = ~we;
  endtask

  task automatic idle_inputs();
    in_valid = 0; memread_enable = 0; memwrite_enable = 0; mem_gnt = 0; mem_rvalid = 0;
  endtask

  // Memory responder: grants after gd REQ cycles, answers rd cycles after the grant.
  task automatic run_op(input logic [31:0] addr, input logic [31:0] rt, input logic [1:0] sz, input logic uns,
                        input logic we, input int gd, input int rd, input logic [31:0] rdata);
    int rq, wc;
    logic granted;
    rq = 0; wc = 0; granted = 0;
    o_valid = 0; o_stall = 0; o_seen = 0; o_unstable = 0; o_lat = -1; o_val = 'x; o_exc = 'x; o_req_resp = 'x;
    drive(addr, rt, sz, uns, we);
    for (int c = 0; c < 60 && !o_valid; c++) begin
      mem_gnt = 0; mem_rvalid = 0;
      if (mem_req) begin
        if (!o_seen) begin
          o_seen = 1; o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
        end else if (mem_addr !== o_addr || mem_be !== o_be || mem_wdata !== o_wdata || mem_we !== o_we) o_unstable = 1;
        if (rq == gd) begin mem_gnt = 1; granted = 1; end
        rq++;
      end else if (granted) begin
        wc++;
        if (wc == rd) begin mem_rvalid = 1; mem_rdata = rdata; end
      end
      #1;
      if (stall) o_stall++;
      if (out_valid) begin o_valid = 1; o_val = out_value; o_exc = exception; o_lat = c; o_req_resp = mem_req; end
      @(posedge clk); #1;
    end
    idle_inputs();
    checks++;
    if (o_valid !== 1'b1) begin failures++; $display("FAIL op_completes addr=%h got out_valid=%b want 1 within 60 cycles", addr, o_valid); end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, out_value, out_valid, stall, exception} !== '0) begin
      failures++; $display("FAIL reset_outputs got req=%b we=%b addr=%h wdata=%h be=%b val=%h ov=%b stall=%b exc=%0d want all 0",
        mem_req, mem_we, mem_addr, mem_wdata, mem_be, out_value, out_valid, stall, exception);
    end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_word_load();
    run_op(32'h10, 0, 2'd2, 0, 0, 0, 1, 32'hDEADBEEF);
    checks++; if (o_lat !== 3) begin failures++; $display("FAIL word_latency got %0d want 3", o_lat); end
    checks++; if (o_stall !== 3) begin failures++; $display("FAIL word_stall_cycles got %0d want 3", o_stall); end
    checks++; if (o_addr !== 14'h4) begin failures++; $display("FAIL word_mem_addr got %h want 0004", o_addr); end
    checks++; if (o_be !== 4'b1111) begin failures++; $display("FAIL word_be got %b want 1111", o_be); end
    checks++; if (o_val !== 32'hDEADBEEF) begin failures++; $display("FAIL word_value got %h want deadbeef", o_val); end
    checks++; if (o_exc !== 3'd0) begin failures++; $display("FAIL word_exception got %0d want 0", o_exc); end
  endtask

  task automatic test_subword_load();
    run_op(32'h13, 0, 2'd0, 0, 0, 0, 1, 32'h80FFFFFF);
    checks++; if (o_val !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_signed got %h want ffffff80", o_val); end
    checks++; if (o_be !== 4'b1000) begin failures++; $display("FAIL lb_be got %b want 1000", o_be); end
    run_op(32'h13, 0, 2'd0, 1, 0, 0, 1, 32'h80FFFFFF);
    checks++; if (o_val !== 32'h00000080) begin failures++; $display("FAIL lb_unsigned got %h want 00000080", o_val); end
    run_op(32'h2, 0, 2'd1, 0, 0, 0, 1, 32'h80011234);
    checks++; if (o_val !== 32'hFFFF8001) begin failures++; $display("FAIL lh_signed got %h want ffff8001", o_val); end
  endtask

  task automatic test_store();
    run_op(32'h21, 32'h12345678, 2'd0, 0, 1, 0, 1, 32'hFFFFFFFF);
    checks++; if (o_we !== 1'b1) begin failures++; $display("FAIL sb_we got %b want 1", o_we); end
    checks++; if (o_be !== 4'b0010) begin failures++; $display("FAIL sb_be got %b want 0010", o_be); end
    checks++; if (o_wdata !== 32'h78787878) begin failures++; $display("FAIL sb_wdata got %h want 78787878", o_wdata); end
    checks++; if (o_val !== 32'h0) begin failures++; $display("FAIL sb_value got %h want 0", o_val); end
    run_op(32'h22, 32'h12345678, 2'd1, 0, 1, 0, 1, 32'hFFFFFFFF);
    checks++; if (o_be !== 4'b1100) begin failures++; $display("FAIL sh_be got %b want 1100", o_be); end
    checks++; if (o_wdata !== 32'h56785678) begin failures++; $display("FAIL sh_wdata got %h want 56785678", o_wdata); end
  endtask

  task automatic test_misaligned();
    drive(32'h2, 0, 2'd2, 0, 0);
    #1;
    checks++; if (exception !== 3'd1) begin failures++; $display("FAIL lw_misaligned_exc got %0d want 1", exception); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lw_misaligned_stall got %b want 0", stall); end
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL lw_misaligned_noreq got req=%b ov=%b want 0 0", mem_req, out_valid); end
    drive(32'h1, 32'hAAAA5555, 2'd1, 0, 1);
    #1;
    checks++; if (exception !== 3'd2) begin failures++; $display("FAIL sh_misaligned_exc got %0d want 2", exception); end
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL sh_misaligned_noreq got req=%b want 0", mem_req); end
    idle_inputs();
    #1;
    checks++; if (exception !== 3'd0) begin failures++; $display("FAIL noop_exc got %0d want 0", exception); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    run_op(32'h40, 0, 2'd2, 0, 0, 1000, 1, 32'h0);
    checks++; if (o_lat !== TIMEOUT + 1) begin failures++; $display("FAIL timeout_latency got %0d want %0d", o_lat, TIMEOUT + 1); end
    checks++; if (o_exc !== 3'd3) begin failures++; $display("FAIL timeout_exc got %0d want 3", o_exc); end
    checks++; if (o_val !== 32'h0) begin failures++; $display("FAIL timeout_value got %h want 0", o_val); end
    checks++; if (o_req_resp !== 1'b0) begin failures++; $display("FAIL timeout_req_drop got %b want 0", o_req_resp); end
    mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    mem_rvalid = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL late_rvalid got ov=%b stall=%b want 0 0", out_valid, stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_disable();
    drive(32'h8, 32'h1, 2'd2, 0, 1);
    alu_memop_disable = 1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL disable_stall got %b want 0", stall); end
    repeat (3) begin
      @(posedge clk); #1;
      checks++; if (mem_req !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL disable_noreq got req=%b ov=%b want 0 0", mem_req, out_valid); end
    end
    alu_memop_disable = 0;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    drive(32'h30, 0, 2'd2, 0, 0);
    @(posedge clk); #1;
    mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0;
    checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL wait_state got stall=%b req=%b want 1 0", stall, mem_req); end
    rst = 1;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, out_value, out_valid, stall, exception} !== '0) begin
      failures++; $display("FAIL reset_mid_outputs got req=%b addr=%h be=%b val=%h ov=%b stall=%b exc=%0d want all 0",
        mem_req, mem_addr, mem_be, out_value, out_valid, stall, exception);
    end
    idle_inputs();
    @(posedge clk); #1;
    rst = 0;
    mem_rvalid = 1; mem_rdata = 32'h12121212;
    @(posedge clk); #1;
    mem_rvalid = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_mid_idle got ov=%b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] addr, rt, rdata;
    logic [1:0] sz;
    logic uns, we;
    int gd, rd;
    for (int i = 0; i < 40; i++) begin
      addr = $urandom; rt = $urandom; rdata = $urandom;
      sz = 2'($urandom_range(0, 3)); uns = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      addr = addr - addr % nbytes(sz);
      gd = $urandom_range(0, 3); rd = $urandom_range(1, 3);
      run_op(addr, rt, sz, uns, we, gd, rd, rdata);
      checks++; if (o_lat !== 2 + gd + rd) begin failures++; $display("FAIL rnd%0d_latency got %0d want %0d", i, o_lat, 2 + gd + rd); end
      checks++; if (o_stall !== 2 + gd + rd) begin failures++; $display("FAIL rnd%0d_stall got %0d want %0d", i, o_stall, 2 + gd + rd); end
      checks++; if (o_addr !== 14'((addr / 4) % 16384)) begin failures++; $display("FAIL rnd%0d_addr got %h want %h", i, o_addr, 14'((addr / 4) % 16384)); end
      checks++; if (o_be !== model_be(addr, sz)) begin failures++; $display("FAIL rnd%0d_be got %b want %b", i, o_be, model_be(addr, sz)); end
      checks++; if (o_we !== we) begin failures++; $display("FAIL rnd%0d_we got %b want %b", i, o_we, we); end
      if (we) begin
        checks++; if (o_wdata !== model_wdata(rt, sz)) begin failures++; $display("FAIL rnd%0d_wdata got %h want %h", i, o_wdata, model_wdata(rt, sz)); end
      end
      checks++; if (o_val !== (we ? 32'd0 : model_load(rdata, addr, sz, uns))) begin
        failures++; $display("FAIL rnd%0d_value got %h want %h", i, o_val, we ? 32'd0 : model_load(rdata, addr, sz, uns));
      end
      checks++; if (o_unstable !== 1'b0 || o_exc !== 3'd0) begin failures++; $display("FAIL rnd%0d_stable_exc got unstable=%b exc=%0d want 0 0", i, o_unstable, o_exc); end
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_subword_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_disable();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
